seq_nr_divider: RTL and testbench

SEQ_NR_DIVIDER -- requirements
Module: seq_nr_divider

---
 rtl/fp_div_pkg.sv | 20 ++
 rtl/nr_step.sv | 18 +
 rtl/seq_nr_divider.sv | 151 +++++++++++++++
 tb/tb_seq_nr_divider.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/fp_div_pkg.sv
// Shared definitions for the sequential non-restoring divider and the float divider top level.
package fp_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_t;

  function automatic int quot_width(input int w, input int frac);
    return w + frac;
  endfunction

  // Iteration counter must hold the value QW itself.
  function automatic int cnt_width(input int qw);
    return $clog2(qw + 1);
  endfunction

endpackage

// File: rtl/nr_step.sv
// One non-restoring add/subtract step on a W+1-bit signed accumulator.
module nr_step #(
  parameter int W = 24
) (
  input  logic [W:0]   acc,
  input  logic [W-1:0] divisor,
  input  logic         mode,
  output logic [W:0]   acc_next,
  output logic         q_bit
);

  // mode=1 subtracts, mode=0 adds; the result sign gives the quotient bit.
  always_comb begin
    acc_next = mode ? (acc - {1'b0, divisor}) : (acc + {1'b0, divisor});
    q_bit    = ~acc_next[W];
  end

endmodule

// File: rtl/seq_nr_divider.sv
// Sequential non-restoring divider: quotient = floor(dividend*2^FRAC / divisor), one bit per cycle.
//
// state | meaning
// IDLE  | ready, waiting for start
// RUN   | one quotient bit per cycle, QW cycles
// FIX   | restore a negative final remainder, latch results
// DONE  | one-cycle done pulse
module seq_nr_divider
  import fp_div_pkg::*;
#(
  parameter int W    = 24,
  parameter int FRAC = 24
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [W-1:0]        dividend,
  input  logic [W-1:0]        divisor,
  output logic                ready,
  output logic                done,
  output logic [W+FRAC-1:0]   quotient,
  output logic [W-1:0]        remainder,
  output logic                sticky,
  output logic                dbz
);

  localparam int QW = quot_width(W, FRAC);
  localparam int CW = cnt_width(QW);
  localparam logic [CW-1:0] CNT_LOAD = CW'(QW);

  div_state_t state_q, state_d;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [W:0]    acc_q, acc_d;
  logic [W-1:0]  dvd_q, dvd_d;
  logic [W-1:0]  dvs_q, dvs_d;
  logic [QW-1:0] quo_q, quo_d;
  logic [QW-1:0] quotient_q, quotient_d;
  logic [W-1:0]  remainder_q, remainder_d;
  logic          sticky_q, sticky_d;
  logic          dbz_q, dbz_d;

  logic          accept;
  logic [W:0]    step_in;
  logic          step_mode;
  logic [W:0]    step_acc;
  logic          step_q;
  logic [W:0]    acc_fix;

  // State register and datapath flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      quo_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      sticky_q    <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      quo_q       <= quo_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      sticky_q    <= sticky_d;
      dbz_q       <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = (divisor == '0) ? ST_DONE : ST_RUN;
      ST_RUN:  if (cnt_q <= CW'(1)) state_d = ST_FIX;
      ST_FIX:  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ready = (state_q == ST_IDLE);
    done  = (state_q == ST_DONE);
  end

  assign accept = ready & start;

  // The single adder serves both the RUN steps and the FIX restore.
  always_comb begin
    step_in   = (state_q == ST_RUN) ? {acc_q[W-1:0], dvd_q[W-1]} : acc_q;
    step_mode = (state_q == ST_RUN) & ~acc_q[W];
  end

  nr_step #(.W(W)) u_nr_step (
    .acc      (step_in),
    .divisor  (dvs_q),
    .mode     (step_mode),
    .acc_next (step_acc),
    .q_bit    (step_q)
  );

  always_comb begin
    acc_fix     = acc_q[W] ? step_acc : acc_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    quo_d       = quo_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    sticky_d    = sticky_q;
    dbz_d       = dbz_q;
    if (accept) begin
      dvd_d = dividend;
      dvs_d = divisor;
      acc_d = '0;
      quo_d = '0;
      cnt_d = CNT_LOAD;
      if (divisor == '0) begin
        quotient_d  = '1;
        remainder_d = dividend;
        sticky_d    = 1'b1;
        dbz_d       = 1'b1;
      end
    end else if (state_q == ST_RUN) begin
      acc_d = step_acc;
      dvd_d = {dvd_q[W-2:0], 1'b0};
      quo_d = {quo_q[QW-2:0], step_q};
      cnt_d = (cnt_q != '0) ? (cnt_q - CW'(1)) : cnt_q;
    end else if (state_q == ST_FIX) begin
      acc_d       = acc_fix;
      quotient_d  = quo_q;
      remainder_d = acc_fix[W-1:0];
      sticky_d    = |acc_fix[W-1:0];
      dbz_d       = 1'b0;
    end
  end

  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign sticky    = sticky_q;
  assign dbz       = dbz_q;

endmodule

// File: tb/tb_seq_nr_divider.sv
// Directed bench for seq_nr_divider in three configurations: 8/0, 8/8 and 24/24 (W/FRAC).
module tb_seq_nr_divider;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int sel = 0;
  logic go = 1'b0;
  logic [23:0] dvd_i = '0;
  logic [23:0] dvs_i = '0;

  logic start_a, start_b, start_c;
  logic ready_a, ready_b, ready_c;
  logic done_a, done_b, done_c;
  logic [7:0]  q_a;
  logic [15:0] q_b;
  logic [47:0] q_c;
  logic [7:0]  r_a, r_b;
  logic [23:0] r_c;
  logic s_a, s_b, s_c, z_a, z_b, z_c;

  assign start_a = go && (sel == 0);
  assign start_b = go && (sel == 1);
  assign start_c = go && (sel == 2);

  seq_nr_divider #(.W(8), .FRAC(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .dividend(dvd_i[7:0]), .divisor(dvs_i[7:0]),
    .ready(ready_a), .done(done_a), .quotient(q_a), .remainder(r_a), .sticky(s_a), .dbz(z_a));

  seq_nr_divider #(.W(8), .FRAC(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .dividend(dvd_i[7:0]), .divisor(dvs_i[7:0]),
    .ready(ready_b), .done(done_b), .quotient(q_b), .remainder(r_b), .sticky(s_b), .dbz(z_b));

  seq_nr_divider dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .dividend(dvd_i), .divisor(dvs_i),
    .ready(ready_c), .done(done_c), .quotient(q_c), .remainder(r_c), .sticky(s_c), .dbz(z_c));

  logic cur_ready, cur_done, cur_s, cur_z;
  logic [47:0] cur_q;
  logic [23:0] cur_r;

  always_comb begin
    cur_ready = ready_a; cur_done = done_a; cur_q = 48'(q_a); cur_r = 24'(r_a);
    cur_s = s_a; cur_z = z_a;
    case (sel)
      1: begin
        cur_ready = ready_b; cur_done = done_b; cur_q = 48'(q_b); cur_r = 24'(r_b);
        cur_s = s_b; cur_z = z_b;
      end
      2: begin
        cur_ready = ready_c; cur_done = done_c; cur_q = q_c; cur_r = r_c;
        cur_s = s_c; cur_z = z_c;
      end
      default: ;
    endcase
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int          sel;
    logic [23:0] dvd;
    logic [23:0] dvs;
    logic [47:0] q;
    logic [23:0] r;
    logic        s;
    logic        z;
    int          lat;
  } vec_t;

  vec_t vecs[16];
  int nv = 0;

  task automatic add(input int s_, input logic [23:0] a, input logic [23:0] b,
                     input logic [47:0] q, input logic [23:0] r, input logic s, input logic z,
                     input int lat);
    vecs[nv] = '{sel: s_, dvd: a, dvs: b, q: q, r: r, s: s, z: z, lat: lat};
    nv++;
  endtask

  // Starts one division and counts negedges until done, which is the latency in accepting-edge units.
  task automatic run_op(input string tag, input vec_t v);
    int n;
    sel = v.sel;
    @(negedge clk);
    chk({tag, "_ready"}, 64'(cur_ready), 64'd1);
    dvd_i = v.dvd; dvs_i = v.dvs; go = 1'b1;
    @(posedge clk);
    #1 go = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cur_done && n < 200);
    chk({tag, "_lat"}, 64'(n), 64'(v.lat));
    chk({tag, "_q"}, 64'(cur_q), 64'(v.q));
    chk({tag, "_r"}, 64'(cur_r), 64'(v.r));
    chk({tag, "_sticky"}, 64'(cur_s), 64'(v.s));
    chk({tag, "_dbz"}, 64'(cur_z), 64'(v.z));
    @(negedge clk);
    chk({tag, "_done_1cyc"}, 64'(cur_done), 64'd0);
    chk({tag, "_q_hold"}, 64'(cur_q), 64'(v.q));
  endtask

  initial begin
    int n, ndone, gap;
    vec_t v;

    add(0, 24'd200,  24'd7,   48'd28,  24'd4,   1'b1, 1'b0, 10);
    add(0, 24'd0,    24'd5,   48'd0,   24'd0,   1'b0, 1'b0, 10);
    add(0, 24'd255,  24'd1,   48'd255, 24'd0,   1'b0, 1'b0, 10);
    add(0, 24'd255,  24'd255, 48'd1,   24'd0,   1'b0, 1'b0, 10);
    add(0, 24'd7,    24'd200, 48'd0,   24'd7,   1'b1, 1'b0, 10);
    add(0, 24'd254,  24'd255, 48'd0,   24'd254, 1'b1, 1'b0, 10);
    add(0, 24'd128,  24'd3,   48'd42,  24'd2,   1'b1, 1'b0, 10);
    add(0, 24'h5A,   24'd0,   48'hFF,  24'h5A,  1'b1, 1'b1, 1);
    add(0, 24'd100,  24'd10,  48'd10,  24'd0,   1'b0, 1'b0, 10);
    add(1, 24'd1,    24'd3,   48'd85,  24'd1,   1'b1, 1'b0, 18);
    add(1, 24'd255,  24'd1,   48'hFF00, 24'd0,  1'b0, 1'b0, 18);
    add(1, 24'd200,  24'd7,   48'd7314, 24'd2,  1'b1, 1'b0, 18);
    add(1, 24'd0,    24'd0,   48'hFFFF, 24'd0,  1'b1, 1'b1, 1);
    add(2, 24'h800000, 24'h800000, 48'h1000000, 24'd0, 1'b0, 1'b0, 50);
    add(2, 24'hFFFFFF, 24'h800000, 48'h1FFFFFE, 24'd0, 1'b0, 1'b0, 50);

    // Reset state, with the clock running.
    repeat (2) @(negedge clk);
    chk("rst_ready_a", 64'(ready_a), 64'd1);
    chk("rst_ready_c", 64'(ready_c), 64'd1);
    chk("rst_done_a", 64'(done_a), 64'd0);
    chk("rst_q_c", 64'(q_c), 64'd0);
    chk("rst_r_a", 64'(r_a), 64'd0);
    chk("rst_sticky_b", 64'(s_b), 64'd0);
    chk("rst_dbz_b", 64'(z_b), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < nv; i++) run_op($sformatf("v%0d", i), vecs[i]);

    // start held high: operands captured at acceptance, back-to-back spacing QW+3.
    sel = 0;
    @(negedge clk);
    dvd_i = 24'd200; dvs_i = 24'd7; go = 1'b1;
    @(posedge clk);
    #1 dvd_i = 24'd100; dvs_i = 24'd10;
    n = 0;
    do begin @(negedge clk); n++; end while (!done_a && n < 100);
    chk("hold_lat", 64'(n), 64'd10);
    chk("hold_q1", 64'(q_a), 64'd28);
    chk("hold_r1", 64'(r_a), 64'd4);
    gap = 0;
    do begin @(negedge clk); gap++; end while (!done_a && gap < 100);
    go = 1'b0;
    chk("hold_gap", 64'(gap), 64'd11);
    chk("hold_q2", 64'(q_a), 64'd10);
    chk("hold_r2", 64'(r_a), 64'd0);

    // A start pulse while busy is neither honoured nor queued.
    @(negedge clk);
    dvd_i = 24'd200; dvs_i = 24'd7; go = 1'b1;
    @(posedge clk);
    #1 go = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 3) begin dvd_i = 24'd9; dvs_i = 24'd2; go = 1'b1; end
      if (n == 4) go = 1'b0;
    end while (!done_a && n < 100);
    chk("busy_lat", 64'(n), 64'd10);
    chk("busy_q", 64'(q_a), 64'd28);
    ndone = 0;
    repeat (20) begin @(negedge clk); if (done_a) ndone++; end
    chk("busy_no_queue", 64'(ndone), 64'd0);
    chk("busy_ready", 64'(ready_a), 64'd1);

    // Reset 5 cycles into RUN aborts with no done pulse.
    @(negedge clk);
    dvd_i = 24'd200; dvs_i = 24'd7; go = 1'b1;
    @(posedge clk);
    #1 go = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_ready", 64'(ready_a), 64'd1);
    chk("abort_done", 64'(done_a), 64'd0);
    chk("abort_q", 64'(q_a), 64'd0);
    chk("abort_r", 64'(r_a), 64'd0);
    chk("abort_sticky", 64'(s_a), 64'd0);
    chk("abort_dbz", 64'(z_a), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (20) begin @(negedge clk); if (done_a) ndone++; end
    chk("abort_no_done", 64'(ndone), 64'd0);
    v = vecs[0];
    run_op("post_rst", v);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
